// File: rtl/ks10_ifq_pkg.sv
// ks10_ifq_pkg: shared types and constants for the KS10 instruction prefetch queue.
//   IFQ_DEPTH   default queue depth (entries and reads in flight)
//   IFQ_AWIDTH  virtual address width (PDP-10 bits 18:35)
//   IFQ_PW      FIFO pointer width derived from IFQ_DEPTH
//   ifq_state_e fetch state (IDLE / RUN / HALT)
//   ifq_entry_t queued word: 36b data, 18b fetch PC, 1b nxm flag
package ks10_ifq_pkg;
    localparam int IFQ_DEPTH  = 4;
    localparam int IFQ_AWIDTH = 18;
    localparam int IFQ_DWIDTH = 36;
    localparam int IFQ_PW     = $clog2(IFQ_DEPTH);
    typedef enum logic [1:0] {
        IFQ_IDLE = 2'd0,
        IFQ_RUN  = 2'd1,
        IFQ_HALT = 2'd2
    } ifq_state_e;
    typedef struct packed {
        logic [IFQ_DWIDTH-1:0] data;
        logic [IFQ_AWIDTH-1:0] pc;
        logic                  nxm;
    } ifq_entry_t;
    localparam int IFQ_ENTRY_W = $bits(ifq_entry_t);
endpackage

// File: rtl/ks10_ifq_fifo.sv
// ks10_ifq_fifo: synchronous FIFO with synchronous clear and registered-storage head.
//   clk, rst   clock, asynchronous active-high reset
//   clr        empties the FIFO (wins over push/pop)
//   push, din  write an entry
//   pop        discard the head entry
//   dout       head entry (storage read, no extra latency)
//   count      occupancy, 0..DEPTH
module ks10_ifq_fifo
    import ks10_ifq_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = IFQ_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [PW:0]   cnt_q, cnt_d;

    always_comb begin
        wp_d  = clr ? '0 : wp_q + PW'(push);
        rp_d  = clr ? '0 : rp_q + PW'(pop);
        cnt_d = clr ? '0 : cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clr) mem[wp_q] <= din;
    end

    assign dout  = mem[rp_q];
    assign count = cnt_q;
endmodule

// File: rtl/ks10_ifetch_queue.sv
// ks10_ifetch_queue: instruction prefetch queue feeding the IR/AC latch.
//   clk, rst               clock, asynchronous active-high reset
//   flush, newpc           redirect: drop queue and in-flight reads, restart at newpc
//   bus_req, bus_addr      sequential read request, address = fetch PC
//   bus_ack                request accepted this cycle
//   bus_vld, bus_data,     in-order read return; bus_nxm marks a non-existent
//   bus_nxm                  memory error for that return
//   ir_valid, ir_ready     head handshake; ir_valid & ir_ready pops
//   ir_data, ir_pc, ir_nxm head word, its fetch address and error flag
module ks10_ifetch_queue
    import ks10_ifq_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [IFQ_AWIDTH-1:0] newpc,
    output logic                  bus_req,
    output logic [IFQ_AWIDTH-1:0] bus_addr,
    input  logic                  bus_ack,
    input  logic                  bus_vld,
    input  logic [IFQ_DWIDTH-1:0] bus_data,
    input  logic                  bus_nxm,
    output logic                  ir_valid,
    input  logic                  ir_ready,
    output logic [IFQ_DWIDTH-1:0] ir_data,
    output logic [IFQ_AWIDTH-1:0] ir_pc,
    output logic                  ir_nxm
);
    localparam int CW = $clog2(DEPTH) + 1;

    ifq_state_e            state_q, state_d;
    logic [IFQ_AWIDTH-1:0] pc_q, pc_d, tag_head;
    logic [CW-1:0]         drop_q, drop_d, count, inflight;
    logic                  hold_q, hold_d;
    logic                  ack, stale, ret, pop;
    ifq_entry_t            wr_e, head;

    // Every accepted, not-yet-returned, non-stale read owns one tag, so the tag
    // FIFO occupancy is the in-flight count.
    ks10_ifq_fifo #(.W(IFQ_ENTRY_W), .DEPTH(DEPTH)) u_data (
        .clk(clk), .rst(rst), .clr(flush), .push(ret), .din(wr_e),
        .pop(pop), .dout(head), .count(count)
    );

    ks10_ifq_fifo #(.W(IFQ_AWIDTH), .DEPTH(DEPTH)) u_tag (
        .clk(clk), .rst(rst), .clr(flush), .push(ack & ~flush), .din(pc_q),
        .pop(ret), .dout(tag_head), .count(inflight)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IFQ_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = flush                                        ? IFQ_RUN  :
                  (state_q == IFQ_RUN && ret && bus_nxm)       ? IFQ_HALT : state_q;
    end

    // Issue guard reserves a queue slot for every read in flight, so a return
    // can never find the data FIFO full.
    always_comb begin
        bus_req  = (state_q == IFQ_RUN) && !hold_q && ((count + inflight) < CW'(DEPTH));
        bus_addr = pc_q;
        ir_valid = count != '0;
        ir_data  = ir_valid ? head.data : '0;
        ir_pc    = ir_valid ? head.pc   : '0;
        ir_nxm   = ir_valid & head.nxm;
    end

    // A flush turns every outstanding read into a stale one: the ones already
    // stale, the tagged ones, plus a same-cycle ack, minus a same-cycle return.
    always_comb begin
        ack    = bus_req & bus_ack;
        stale  = bus_vld & (drop_q != '0);
        ret    = bus_vld & ~stale & ~flush;
        pop    = ir_valid & ir_ready & ~flush;
        wr_e   = '{data: bus_nxm ? '0 : bus_data, pc: tag_head, nxm: bus_nxm};
        pc_d   = flush ? newpc : ack ? pc_q + 1'b1 : pc_q;
        drop_d = flush ? drop_q + inflight + CW'(ack) - CW'(bus_vld) : drop_q - CW'(stale);
        hold_d = flush;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q   <= '0;
            drop_q <= '0;
            hold_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            drop_q <= drop_d;
            hold_q <= hold_d;
        end
    end
endmodule
